// File: rtl/datapath_pkg.sv
// Shared encodings for the processor datapath and its controller:
// bus sources, register load bits, ALU opcodes and memory FSM states.
package datapath_pkg;

   localparam int DEFAULT_DATA_W = 16;

   localparam logic [3:0] SRC_ZERO = 4'd0;
   localparam logic [3:0] SRC_PC   = 4'd1;
   localparam logic [3:0] SRC_DR   = 4'd2;
   localparam logic [3:0] SRC_IR   = 4'd3;
   localparam logic [3:0] SRC_AC   = 4'd4;
   localparam logic [3:0] SRC_RA   = 4'd5;
   localparam logic [3:0] SRC_RB   = 4'd6;
   localparam logic [3:0] SRC_RC   = 4'd7;
   localparam logic [3:0] SRC_R1   = 4'd8;
   localparam logic [3:0] SRC_R2   = 4'd9;
   localparam logic [3:0] SRC_TR   = 4'd10;

   localparam int LD_PC = 0;
   localparam int LD_AR = 1;
   localparam int LD_DR = 2;
   localparam int LD_AC = 3;
   localparam int LD_RA = 4;
   localparam int LD_RB = 5;
   localparam int LD_RC = 6;
   localparam int LD_R1 = 7;
   localparam int LD_R2 = 8;
   localparam int LD_TR = 9;

   localparam logic [2:0] ALU_NOP  = 3'd0;
   localparam logic [2:0] ALU_PASS = 3'd1;
   localparam logic [2:0] ALU_ADD  = 3'd2;
   localparam logic [2:0] ALU_SUB  = 3'd3;
   localparam logic [2:0] ALU_MUL  = 3'd4;
   localparam logic [2:0] ALU_AND  = 3'd5;
   localparam logic [2:0] ALU_OR   = 3'd6;
   localparam logic [2:0] ALU_XOR  = 3'd7;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_RD   = 2'd1,
      MEM_WR   = 2'd2
   } memState_t;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: a is the accumulator, b is the shared bus.
// All arithmetic wraps to DATA_W bits.
module datapath_alu
   import datapath_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   always_comb begin
      result = '0;
      case (op)
         ALU_PASS: result = b;
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_MUL:  result = a * b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/datapath_core.sv
// Processor datapath: register set, shared bus, ALU, Z flag and the
// memory-port handshake that stalls the controller during accesses.
module datapath_core
   import datapath_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        A_bus,
   input  logic [9:0]        C_bus,
   input  logic [2:0]        ALU,
   input  logic              LDIR,
   input  logic              PC_INC,
   input  logic              AC_INC,
   input  logic              RA_INC,
   input  logic              RB_INC,
   input  logic              RC_INC,
   input  logic              read,
   input  logic              write,
   output logic [5:0]        IR,
   output logic [DATA_W-1:0] out,
   output logic              Z_Flag,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam logic [DATA_W-1:0] INC_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] r_pc, r_ar, r_dr, r_ac, r_ra, r_rb, r_rc, r_r1, r_r2, r_tr;
   logic [5:0]        r_ir;
   logic              r_z;
   memState_t         r_state;
   logic              r_mem_req, r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic [DATA_W-1:0] w_bus, w_alu_result;
   logic              w_alu_zero, w_ctrl_en, w_alu_en, w_rd_done;

   // The whole control word is frozen while a memory access is outstanding.
   assign w_ctrl_en = (r_state == MEM_IDLE);
   assign w_alu_en  = w_ctrl_en && (ALU != ALU_NOP);
   assign w_rd_done = (r_state == MEM_RD) && mem_ack;

   always_comb begin
      w_bus = '0;
      case (A_bus)
         SRC_PC:  w_bus = r_pc;
         SRC_DR:  w_bus = r_dr;
         SRC_IR:  w_bus = {{(DATA_W-6){1'b0}}, r_ir};
         SRC_AC:  w_bus = r_ac;
         SRC_RA:  w_bus = r_ra;
         SRC_RB:  w_bus = r_rb;
         SRC_RC:  w_bus = r_rc;
         SRC_R1:  w_bus = r_r1;
         SRC_R2:  w_bus = r_r2;
         SRC_TR:  w_bus = r_tr;
         default: w_bus = '0;
      endcase
   end

   datapath_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (r_ac),
      .b      (w_bus),
      .op     (ALU),
      .result (w_alu_result),
      .zero   (w_alu_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= '0;
         r_ar <= '0;
         r_dr <= '0;
         r_ac <= '0;
         r_ra <= '0;
         r_rb <= '0;
         r_rc <= '0;
         r_r1 <= '0;
         r_r2 <= '0;
         r_tr <= '0;
         r_ir <= '0;
         r_z  <= 1'b0;
      end else if (w_ctrl_en) begin
         if (C_bus[LD_PC])    r_pc <= w_bus;
         else if (PC_INC)     r_pc <= r_pc + INC_ONE;
         if (C_bus[LD_AR])    r_ar <= w_bus;
         if (C_bus[LD_DR])    r_dr <= w_bus;
         if (w_alu_en)        r_ac <= w_alu_result;
         else if (C_bus[LD_AC]) r_ac <= w_bus;
         else if (AC_INC)     r_ac <= r_ac + INC_ONE;
         if (C_bus[LD_RA])    r_ra <= w_bus;
         else if (RA_INC)     r_ra <= r_ra + INC_ONE;
         if (C_bus[LD_RB])    r_rb <= w_bus;
         else if (RB_INC)     r_rb <= r_rb + INC_ONE;
         if (C_bus[LD_RC])    r_rc <= w_bus;
         else if (RC_INC)     r_rc <= r_rc + INC_ONE;
         if (C_bus[LD_R1])    r_r1 <= w_bus;
         if (C_bus[LD_R2])    r_r2 <= w_bus;
         if (C_bus[LD_TR])    r_tr <= w_bus;
         if (LDIR)            r_ir <= r_dr[5:0];
         if (w_alu_en)        r_z  <= w_alu_zero;
      end else if (w_rd_done) begin
         r_dr <= mem_rdata;
      end
   end

   // A simultaneous read and write request is served as a read only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= MEM_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            MEM_IDLE: begin
               if (read) begin
                  r_state    <= MEM_RD;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_ar[ADDR_W-1:0];
               end else if (write) begin
                  r_state     <= MEM_WR;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_ar[ADDR_W-1:0];
                  r_mem_wdata <= r_dr;
               end
            end
            MEM_RD, MEM_WR: begin
               if (mem_ack) begin
                  r_state   <= MEM_IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
               end
            end
            default: begin
               r_state   <= MEM_IDLE;
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
            end
         endcase
      end
   end

   assign IR        = r_ir;
   assign out       = r_ac;
   assign Z_Flag    = r_z;
   assign stall     = (r_state != MEM_IDLE);
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_datapath_core.sv
// Scoreboard bench for datapath_core: directed control words push expected
// observations; monitors pop and compare them and check memory requests.
module tb_datapath_core;

   localparam int W = 16;

   localparam int SEL_OUT   = 0;
   localparam int SEL_Z     = 1;
   localparam int SEL_IR    = 2;
   localparam int SEL_STALL = 3;
   localparam int SEL_REQ   = 4;
   localparam int SEL_WE    = 5;
   localparam int SEL_ADDR  = 6;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_LDIR = 6'b100000;
   localparam logic [5:0] S_PC   = 6'b010000;
   localparam logic [5:0] S_AC   = 6'b001000;
   localparam logic [5:0] S_RA   = 6'b000100;
   localparam logic [5:0] S_ALL  = 6'b111111;

   typedef struct {
      string       name;
      int          sel;
      logic [15:0] exp;
   } regCheck_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } memCheck_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    A_bus = '0;
   logic [9:0]    C_bus = '0;
   logic [2:0]    ALU = '0;
   logic          LDIR = 1'b0, PC_INC = 1'b0, AC_INC = 1'b0;
   logic          RA_INC = 1'b0, RB_INC = 1'b0, RC_INC = 1'b0;
   logic          read = 1'b0, write = 1'b0;
   logic [5:0]    IR;
   logic [W-1:0]  out;
   logic          Z_Flag, stall, mem_req, mem_we;
   logic [15:0]   mem_addr;
   logic [W-1:0]  mem_wdata;
   logic [W-1:0]  mem_rdata = '0;
   logic          mem_ack = 1'b0;

   regCheck_t regQ[$];
   memCheck_t memQ[$];
   memCheck_t curMem;
   regCheck_t curReg;
   logic      memActive = 1'b0;
   logic      prevReq = 1'b0;
   logic [15:0] actVal;
   int        checks = 0;
   int        errors = 0;

   datapath_core #(.DATA_W(W), .ADDR_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A_bus     (A_bus),
      .C_bus     (C_bus),
      .ALU       (ALU),
      .LDIR      (LDIR),
      .PC_INC    (PC_INC),
      .AC_INC    (AC_INC),
      .RA_INC    (RA_INC),
      .RB_INC    (RB_INC),
      .RC_INC    (RC_INC),
      .read      (read),
      .write     (write),
      .IR        (IR),
      .out       (out),
      .Z_Flag    (Z_Flag),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   // Drive one control word across one rising edge, then return to idle.
   task automatic applyStimulus(input logic [3:0] a, input logic [9:0] c,
                                input logic [2:0] alu, input logic [5:0] str,
                                input logic rd, input logic wr);
      A_bus  = a;
      C_bus  = c;
      ALU    = alu;
      {LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC} = str;
      read   = rd;
      write  = wr;
      @(negedge clk);
      A_bus  = '0;
      C_bus  = '0;
      ALU    = '0;
      {LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC} = '0;
      read   = 1'b0;
      write  = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int sel, input logic [15:0] exp);
      regCheck_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      regQ.push_back(e);
   endtask

   task automatic expectMem(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      memCheck_t e;
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      memQ.push_back(e);
   endtask

   task automatic memAck(input logic [W-1:0] data);
      mem_ack   = 1'b1;
      mem_rdata = data;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic incAc(input int n);
      for (int i = 0; i < n; i++) applyStimulus(4'd0, 10'd0, 3'd0, S_AC, 1'b0, 1'b0);
   endtask

   // Register/flag monitor: drains pending expectations mid-low-phase.
   always @(negedge clk) begin
      #2;
      while (regQ.size() > 0) begin
         curReg = regQ.pop_front();
         case (curReg.sel)
            SEL_OUT:   actVal = out;
            SEL_Z:     actVal = {15'd0, Z_Flag};
            SEL_IR:    actVal = {10'd0, IR};
            SEL_STALL: actVal = {15'd0, stall};
            SEL_REQ:   actVal = {15'd0, mem_req};
            SEL_WE:    actVal = {15'd0, mem_we};
            default:   actVal = mem_addr;
         endcase
         checks++;
         if (actVal !== curReg.exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", curReg.name, actVal, curReg.exp);
         end
      end
   end

   // Memory monitor: a rising mem_req presents a request; it must match the
   // next expected transaction and stay stable until it drops.
   always @(negedge clk) begin
      #2;
      if (mem_req && !prevReq) begin
         checks++;
         if (memQ.size() == 0) begin
            errors++;
            memActive = 1'b0;
            $display("[TB] FAIL unexpected_req: got addr 0x%04h we %0b, expected no request", mem_addr, mem_we);
         end else begin
            curMem = memQ.pop_front();
            memActive = 1'b1;
         end
      end
      if (!mem_req) memActive = 1'b0;
      if (mem_req && memActive) begin
         checks++;
         if (mem_we !== curMem.we || mem_addr !== curMem.addr) begin
            errors++;
            $display("[TB] FAIL mem_cmd: got we %0b addr 0x%04h, expected we %0b addr 0x%04h",
                     mem_we, mem_addr, curMem.we, curMem.addr);
         end
         if (curMem.we) begin
            checks++;
            if (mem_wdata !== curMem.wdata) begin
               errors++;
               $display("[TB] FAIL mem_wdata: got 0x%04h, expected 0x%04h", mem_wdata, curMem.wdata);
            end
         end
      end
      prevReq = mem_req;
   end

   initial begin
      $display("[TB] datapath_core scoreboard bench");
      checkOutput("rst_out", SEL_OUT, 16'h0000);
      checkOutput("rst_z", SEL_Z, 16'h0000);
      checkOutput("rst_ir", SEL_IR, 16'h0000);
      checkOutput("rst_stall", SEL_STALL, 16'h0000);
      checkOutput("rst_req", SEL_REQ, 16'h0000);
      checkOutput("rst_we", SEL_WE, 16'h0000);
      checkOutput("rst_addr", SEL_ADDR, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Clear everything, count AC up, copy AC into RA.
      applyStimulus(4'd0, 10'h3FF, 3'd0, S_NONE, 1'b0, 1'b0);
      checkOutput("clear_all", SEL_OUT, 16'h0000);
      incAc(3);
      checkOutput("ac_inc3", SEL_OUT, 16'h0003);
      applyStimulus(4'd4, 10'h010, 3'd0, S_NONE, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(4'd0, 10'd0, 3'd0, S_RA, 1'b0, 1'b0);
      incAc(2);
      applyStimulus(4'd5, 10'd0, 3'd3, S_NONE, 1'b0, 1'b0);
      checkOutput("sub_zero", SEL_OUT, 16'h0000);
      checkOutput("sub_z", SEL_Z, 16'h0001);

      // Build RB = 0xFFFF via 0 - 1, then wrap-around add.
      incAc(1);
      applyStimulus(4'd4, 10'h020, 3'd0, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd0, 10'd0, 3'd1, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd6, 10'd0, 3'd3, S_NONE, 1'b0, 1'b0);
      checkOutput("sub_wrap", SEL_OUT, 16'hFFFF);
      checkOutput("sub_wrap_z", SEL_Z, 16'h0000);
      applyStimulus(4'd4, 10'h020, 3'd0, S_NONE, 1'b0, 1'b0);
      incAc(1);
      checkOutput("inc_wrap", SEL_OUT, 16'h0000);
      incAc(1);
      checkOutput("inc_z_hold", SEL_Z, 16'h0000);
      applyStimulus(4'd6, 10'd0, 3'd2, S_NONE, 1'b0, 1'b0);
      checkOutput("add_wrap", SEL_OUT, 16'h0000);
      checkOutput("add_wrap_z", SEL_Z, 16'h0001);
      applyStimulus(4'd6, 10'd0, 3'd0, S_AC, 1'b0, 1'b0);
      checkOutput("nop_inc", SEL_OUT, 16'h0001);
      checkOutput("nop_z_hold", SEL_Z, 16'h0001);

      // Remaining ALU ops with R1 = 3.
      incAc(2);
      applyStimulus(4'd4, 10'h080, 3'd0, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd8, 10'd0, 3'd4, S_NONE, 1'b0, 1'b0);
      checkOutput("mul", SEL_OUT, 16'h0009);
      checkOutput("mul_z", SEL_Z, 16'h0000);
      applyStimulus(4'd6, 10'd0, 3'd6, S_NONE, 1'b0, 1'b0);
      checkOutput("or", SEL_OUT, 16'hFFFF);
      applyStimulus(4'd8, 10'd0, 3'd7, S_NONE, 1'b0, 1'b0);
      checkOutput("xor", SEL_OUT, 16'hFFFC);
      applyStimulus(4'd8, 10'd0, 3'd5, S_NONE, 1'b0, 1'b0);
      checkOutput("and", SEL_OUT, 16'h0000);
      checkOutput("and_z", SEL_Z, 16'h0001);

      // Priority: ALU over C_bus[3] over AC_INC; PC load over PC_INC.
      incAc(4);
      applyStimulus(4'd4, 10'h100, 3'd0, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd9, 10'd0, 3'd4, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd4, 10'h200, 3'd0, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd0, 10'd0, 3'd1, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd10, 10'h008, 3'd0, S_AC, 1'b0, 1'b0);
      checkOutput("load_over_inc", SEL_OUT, 16'h0010);
      applyStimulus(4'd10, 10'd0, 3'd2, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd4, 10'h040, 3'd0, S_NONE, 1'b0, 1'b0);
      incAc(1);
      applyStimulus(4'd7, 10'h008, 3'd1, S_AC, 1'b0, 1'b0);
      checkOutput("pass_over_load", SEL_OUT, 16'h0020);
      applyStimulus(4'd7, 10'h008, 3'd2, S_AC, 1'b0, 1'b0);
      checkOutput("add_over_load", SEL_OUT, 16'h0040);
      applyStimulus(4'd10, 10'h001, 3'd0, S_PC, 1'b0, 1'b0);
      applyStimulus(4'd1, 10'd0, 3'd1, S_NONE, 1'b0, 1'b0);
      checkOutput("pc_load_over_inc", SEL_OUT, 16'h0010);
      applyStimulus(4'd0, 10'd0, 3'd0, S_PC, 1'b0, 1'b0);
      applyStimulus(4'd1, 10'd0, 3'd1, S_NONE, 1'b0, 1'b0);
      checkOutput("pc_inc", SEL_OUT, 16'h0011);

      // Read from 0x0042 with three wait cycles; controls during stall are ignored.
      applyStimulus(4'd10, 10'd0, 3'd1, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd7, 10'd0, 3'd2, S_NONE, 1'b0, 1'b0);
      applyStimulus(4'd10, 10'd0, 3'd2, S_NONE, 1'b0, 1'b0);
      incAc(2);
      applyStimulus(4'd4, 10'h002, 3'd0, S_NONE, 1'b0, 1'b0);
      expectMem(1'b0, 16'h0042, 16'h0000);
      applyStimulus(4'd0, 10'd0, 3'd0, S_AC, 1'b1, 1'b0);
      checkOutput("rd_stall0", SEL_STALL, 16'h0001);
      checkOutput("rd_same_cycle_inc", SEL_OUT, 16'h0043);
      checkOutput("rd_req", SEL_REQ, 16'h0001);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'd4, 10'h3FF, 3'd2, S_ALL, 1'b1, 1'b1);
         checkOutput("rd_stall_wait", SEL_STALL, 16'h0001);
         checkOutput("rd_frozen_ac", SEL_OUT, 16'h0043);
      end
      AC_INC = 1'b1;
      ALU    = 3'd2;
      A_bus  = 4'd4;
      memAck(16'h1234);
      AC_INC = 1'b0;
      ALU    = '0;
      A_bus  = '0;
      checkOutput("rd_done_stall", SEL_STALL, 16'h0000);
      checkOutput("rd_done_req", SEL_REQ, 16'h0000);
      checkOutput("rd_ack_frozen_ac", SEL_OUT, 16'h0043);
      checkOutput("rd_ir_ignored", SEL_IR, 16'h0000);
      applyStimulus(4'd0, 10'd0, 3'd0, S_LDIR, 1'b0, 1'b0);
      checkOutput("ldir", SEL_IR, 16'h0034);
      applyStimulus(4'd2, 10'd0, 3'd1, S_NONE, 1'b0, 1'b0);
      checkOutput("dr_read", SEL_OUT, 16'h1234);
      applyStimulus(4'd3, 10'd0, 3'd1, S_NONE, 1'b0, 1'b0);
      checkOutput("ir_on_bus", SEL_OUT, 16'h0034);

      // Fetch 0xBEEF into DR from 0x0007, then read+write and plain write.
      applyStimulus(4'd0, 10'd0, 3'd1, S_NONE, 1'b0, 1'b0);
      incAc(7);
      applyStimulus(4'd4, 10'h002, 3'd0, S_NONE, 1'b0, 1'b0);
      expectMem(1'b0, 16'h0007, 16'h0000);
      applyStimulus(4'd0, 10'd0, 3'd0, S_NONE, 1'b1, 1'b0);
      memAck(16'hBEEF);
      checkOutput("rd1_min_stall", SEL_STALL, 16'h0000);
      expectMem(1'b0, 16'h0007, 16'h0000);
      applyStimulus(4'd0, 10'd0, 3'd0, S_NONE, 1'b1, 1'b1);
      checkOutput("rw_is_read", SEL_WE, 16'h0000);
      memAck(16'hBEEF);
      expectMem(1'b1, 16'h0007, 16'hBEEF);
      applyStimulus(4'd0, 10'd0, 3'd0, S_NONE, 1'b0, 1'b1);
      checkOutput("wr_we", SEL_WE, 16'h0001);
      checkOutput("wr_addr", SEL_ADDR, 16'h0007);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(4'd0, 10'd0, 3'd0, S_NONE, 1'b0, 1'b0);
         checkOutput("wr_stall_wait", SEL_STALL, 16'h0001);
      end
      memAck(16'h0000);
      checkOutput("wr_done_stall", SEL_STALL, 16'h0000);
      checkOutput("wr_done_req", SEL_REQ, 16'h0000);
      applyStimulus(4'd0, 10'd0, 3'd0, S_LDIR, 1'b0, 1'b0);
      checkOutput("ldir_beef", SEL_IR, 16'h002F);

      // Short asynchronous reset pulse between edges while a read is pending.
      expectMem(1'b0, 16'h0007, 16'h0000);
      applyStimulus(4'd0, 10'd0, 3'd0, S_NONE, 1'b1, 1'b0);
      checkOutput("pre_rst_stall", SEL_STALL, 16'h0001);
      #3 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("arst_req", SEL_REQ, 16'h0000);
      checkOutput("arst_stall", SEL_STALL, 16'h0000);
      checkOutput("arst_out", SEL_OUT, 16'h0000);
      checkOutput("arst_z", SEL_Z, 16'h0000);
      checkOutput("arst_ir", SEL_IR, 16'h0000);
      checkOutput("arst_addr", SEL_ADDR, 16'h0000);
      incAc(1);
      applyStimulus(4'd2, 10'd0, 3'd1, S_NONE, 1'b0, 1'b0);
      checkOutput("arst_dr", SEL_OUT, 16'h0000);
      checkOutput("arst_dr_z", SEL_Z, 16'h0001);

      repeat (2) @(negedge clk);
      #4;
      checks++;
      if (regQ.size() != 0 || memQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d reg and %0d mem pending, expected 0 and 0",
                  regQ.size(), memQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
